grn_node_lut: RTL
=================

// Module: grn_node_lut
// PURPOSE
//  Parametrised Boolean-network node with two state copies for attractor/cycle search.
//  s0 is the slow copy: it updates once every SLOW_DIV start_s0 strobes. s1 is the fast copy:
//  it updates on every start_s1 strobe.
//  Next state is a configurable function of NUM_IN regulator inputs, with a per-input inhibition mask.
//  The function is OR, AND, threshold, or a runtime-loadable truth table.
//  One instance per gene in the network array; the controller drives the strobes and compares s0/s1.
// PARAMETERS
//  NUM_IN    3        number of regulator inputs (1..6)
//  MODE      0        0=OR, 1=AND, 2=threshold (popcount>=THRESH), 3=truth table (LUT)
//  THRESH    2        threshold for MODE 2 (1..NUM_IN)
//  INV_MASK  0        NUM_IN bits; bit i=1 inverts input i before evaluation (inhibitory edge)
//  SLOW_DIV  2        start_s0 strobes per s0 update (>=1)
//  LUT_INIT  0        2**NUM_IN bits; truth-table reset value, indexed by effective-input vector
// PORTS
//  clk        in   1           clock, rising edge
//  rst_n      in   1           asynchronous reset, active low
//  reset_nos  in   1           synchronous network reload to init_state
//  init_state in   1           value loaded into s0/s1 on reset_nos
//  start_s0   in   1           slow-copy step strobe
//  start_s1   in   1           fast-copy step strobe
//  in_s0      in   NUM_IN      regulator values, slow copy
//  in_s1      in   NUM_IN      regulator values, fast copy
//  lut_we     in   1           truth-table write enable (MODE 3 only; ignored otherwise)
//  lut_wdata  in   2**NUM_IN   new truth table
//  s0         out  1           slow-copy state (registered)
//  s1         out  1           fast-copy state (registered)
//  s0_upd     out  1           1-cycle pulse, high while a freshly written s0 is first visible
//  s1_upd     out  1           1-cycle pulse, high while a freshly written s1 is first visible
//  match      out  1           registered s0==s1, refreshed on every cycle
// BEHAVIOUR
//  rst_n=0 (async): s0=0, s1=0, s0_upd=0, s1_upd=0, match=1, div_cnt=0, lut=LUT_INIT.
//  Effective inputs: e_x = in_sx ^ INV_MASK.
//  f(e): MODE0 |e; MODE1 &e; MODE2 popcount(e)>=THRESH; MODE3 lut[e].
//  popcount width is clog2(NUM_IN+1); there is no overflow.
//  div_cnt width is max(1,clog2(SLOW_DIV)). Priority per edge: reset_nos > start_sx.
//  reset_nos=1: s0<=init_state, s1<=init_state, div_cnt<=SLOW_DIV-1, s0_upd<=0, s1_upd<=0.
//   Because div_cnt is preloaded, the first start_s0 after a reload updates s0.
//  start_s0 with div_cnt==SLOW_DIV-1: s0<=f(e_0), div_cnt<=0, s0_upd<=1.
//  start_s0 otherwise: div_cnt<=div_cnt+1, s0 holds, s0_upd<=0.
//   After rst_n the first update therefore comes on strobe SLOW_DIV.
//  SLOW_DIV=1: s0 updates on every start_s0.
//  start_s1: s1<=f(e_1), s1_upd<=1. With no strobe, the corresponding *_upd<=0.
//  start_s0 and start_s1 are independent. Both may be high in the same cycle, and both copies then update.
//  Latency: new state and upd pulse appear 1 cycle after the strobe.
//   match reflects the new states 1 cycle after that, i.e. 2 cycles after the strobe.
//  lut_we: lut<=lut_wdata at the edge. Evaluations in the same cycle use the old table; the new table is used from the next cycle.
//   lut_we is not affected by reset_nos; only rst_n restores LUT_INIT.
//  Inputs are sampled only on strobe cycles; in_sx may change freely otherwise.
//  rst_n asserted mid-sequence clears everything immediately. Released state equals the reset values above.
// TESTING
//  MODE0, INV_MASK=0, in_s1=3'b000 then 3'b010, start_s1 each -> s1=0 then 1; s1_upd pulses each time.
//  MODE0, SLOW_DIV=2: reset_nos(init=0), in_s0=3'b001, then 4 start_s0 strobes.
//   -> s0=1 after strobe 1; no update on strobes 2 and 4; strobe 3 updates.
//  MODE2 THRESH=2, INV_MASK=3'b100, in_s1=3'b100 -> e=000, s1=0;
//   in_s1=3'b011 -> e=111, s1=1 (inhibited input 2 counts when low).
//  MODE3 LUT_INIT=8'h80: in_s1=3'b111 -> s1=1; in_s1=3'b110 -> s1=0.
//   Then lut_we with 8'h40 in the same cycle as a start_s1 strobe, in_s1=3'b110 -> s1=0 (old table).
//   Next strobe with in_s1=3'b110 -> s1=1.
//  reset_nos and start_s0/start_s1 high together (init=1, all inputs 0, MODE0) -> s0=s1=1, no upd pulses.
//   match=1 two cycles later.
//  rst_n pulsed low mid-run after lut_we -> all outputs at reset values asynchronously, match=1;
//   the table is back to LUT_INIT and div_cnt=0.

Source files
------------

// File: rtl/grn_node_lut.sv
// Boolean-network gene node: a slow (s0) and a fast (s1) copy of one gene state,
// each advanced by its own strobe through a configurable regulatory function.
module grn_node_lut #(
  parameter int                     NUM_IN   = 3,
  parameter int                     MODE     = 0,
  parameter int                     THRESH   = 2,
  parameter logic [NUM_IN-1:0]      INV_MASK = '0,
  parameter int                     SLOW_DIV = 2,
  parameter logic [(1<<NUM_IN)-1:0] LUT_INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reset_nos,
  input  logic                     init_state,
  input  logic                     start_s0,
  input  logic                     start_s1,
  input  logic [NUM_IN-1:0]        in_s0,
  input  logic [NUM_IN-1:0]        in_s1,
  input  logic                     lut_we,
  input  logic [(1<<NUM_IN)-1:0]   lut_wdata,
  output logic                     s0,
  output logic                     s1,
  output logic                     s0_upd,
  output logic                     s1_upd,
  output logic                     match
);

  localparam int LUT_W = 1 << NUM_IN;
  localparam int CNT_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int PC_W  = $clog2(NUM_IN + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SLOW_DIV - 1);

  logic [LUT_W-1:0]  lut;
  logic [CNT_W-1:0]  div_cnt;
  logic [NUM_IN-1:0] eff_s0_p0;
  logic [NUM_IN-1:0] eff_s1_p0;
  logic              nxt_s0_p0;
  logic              nxt_s1_p0;

  // Regulatory function of the effective (post-inhibition) input vector.
  function automatic logic node_eval(input logic [NUM_IN-1:0] e,
                                     input logic [LUT_W-1:0]  tbl);
    logic [PC_W-1:0] pc;
    pc = '0;
    for (int i = 0; i < NUM_IN; i++) pc = pc + PC_W'(e[i]);
    case (MODE)
      0:       node_eval = |e;
      1:       node_eval = &e;
      2:       node_eval = (pc >= PC_W'(THRESH));
      default: node_eval = tbl[e];
    endcase
  endfunction

  assign eff_s0_p0 = in_s0 ^ INV_MASK;
  assign eff_s1_p0 = in_s1 ^ INV_MASK;
  assign nxt_s0_p0 = node_eval(eff_s0_p0, lut);
  assign nxt_s1_p0 = node_eval(eff_s1_p0, lut);

  // Stage p0 -> p1: state copies, update pulses and the divided slow strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0      <= 1'b0;
      s1      <= 1'b0;
      s0_upd  <= 1'b0;
      s1_upd  <= 1'b0;
      match   <= 1'b1;
      div_cnt <= '0;
    end else begin
      match <= (s0 == s1);
      if (reset_nos) begin
        s0      <= init_state;
        s1      <= init_state;
        div_cnt <= DIV_LAST;
        s0_upd  <= 1'b0;
        s1_upd  <= 1'b0;
      end else begin
        s0_upd <= 1'b0;
        s1_upd <= 1'b0;
        if (start_s0) begin
          if (div_cnt == DIV_LAST) begin
            s0      <= nxt_s0_p0;
            div_cnt <= '0;
            s0_upd  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end
        if (start_s1) begin
          s1     <= nxt_s1_p0;
          s1_upd <= 1'b1;
        end
      end
    end
  end

  // Truth table survives network reloads; only the hard reset restores it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut <= LUT_INIT;
    end else if (lut_we && (MODE == 3)) begin
      lut <= lut_wdata;
    end
  end

endmodule
